his_peak_finder: RTL and testbench

- Downstream consumer of the histogram builder.
- After an acquisition set finishes (acq_count_finish pulse), scans the completed histogram bank one pixel at a time through a 1-cycle-latency read port.
- Finds the peak bin and its count per pixel and emits one result per pixel over a valid/ready handshake to the distance/output stage.
- Works on the bank named by hisNum at start, while the builder fills the other bank.

---
 rtl/his_peak_finder_pkg.sv | 32 +++
 rtl/his_peak_finder_peak_tracker.sv | 57 +++++
 rtl/his_peak_finder.sv | 157 +++++++++++++++
 tb/tb_his_peak_finder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/his_peak_finder_pkg.sv
// -----------------------------------------------------------------------------
// his_peak_finder_pkg
//   Shared definitions for the histogram builder and the peak finder.
//   - Default geometry: bin index width, pixels per RAM, count width,
//     minimum valid peak and pixel index width.
//   - Scan FSM state encoding.
//   - his_addr(): histogram RAM address packing (pixel * 2**NB + bin). Both
//     blocks use it so that they agree on the RAM layout.
// -----------------------------------------------------------------------------
package his_peak_finder_pkg;

    localparam int HPF_NB        = 5;
    localparam int HPF_PIXEL_NUM = 4;
    localparam int HPF_CNT_W     = 8;
    localparam int HPF_MIN_PEAK  = 2;
    localparam int HPF_PIX_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_EMIT  = 2'd3
    } hpf_state_e;

    // Histogram RAM word address of (pixel, bin). Callers size-cast the result.
    function automatic logic [31:0] his_addr(input logic [31:0] pix,
                                             input logic [31:0] bin,
                                             input int          nb);
        return (pix << nb) + bin;
    endfunction

endpackage

// File: rtl/his_peak_finder_peak_tracker.sv
// -----------------------------------------------------------------------------
// his_peak_finder_peak_tracker
//   Running maximum / arg-max over the bins of one pixel.
//   Ports:
//     clk, res      clock, synchronous active-high reset
//     clear_i       clear max and index
//     data_valid_i  data_i/bin_i carry a returned bin this cycle
//     data_i        bin count
//     bin_i         bin index of data_i
//     max_o, idx_o  current maximum count and its bin
//   Bin 0 loads unconditionally so each pixel starts fresh without an explicit
//   clear. Later bins replace the maximum only when strictly greater, so the
//   lowest bin wins ties.
// -----------------------------------------------------------------------------
module his_peak_finder_peak_tracker #(
    parameter int NB    = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clear_i,
    input  logic             data_valid_i,
    input  logic [CNT_W-1:0] data_i,
    input  logic [NB-1:0]    bin_i,
    output logic [CNT_W-1:0] max_o,
    output logic [NB-1:0]    idx_o
);

    logic [CNT_W-1:0] max_q, max_d;
    logic [NB-1:0]    idx_q, idx_d;

    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        if (clear_i) begin
            max_d = '0;
            idx_d = '0;
        end else if (data_valid_i && ((bin_i == '0) || (data_i > max_q))) begin
            max_d = data_i;
            idx_d = bin_i;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            max_q <= '0;
            idx_q <= '0;
        end else begin
            max_q <= max_d;
            idx_q <= idx_d;
        end
    end

    assign max_o = max_q;
    assign idx_o = idx_q;

endmodule

// File: rtl/his_peak_finder.sv
// -----------------------------------------------------------------------------
// his_peak_finder
//   Scans a completed histogram bank pixel by pixel after an acquisition set
//   finishes and reports the peak bin / count of each pixel over valid/ready.
//   Ports:
//     clk, res        clock, synchronous active-high reset
//     start, bank_in  scan request pulse and bank to scan (sampled together)
//     rd_en, rd_bank, rd_addr, rd_data
//                     histogram read port, data returns 1 cycle after rd_en
//     out_valid, out_ready, out_pixel, out_bin, out_count, out_no_target
//                     per-pixel result handshake; fields read 0 when not valid
//     busy            a scan is in progress
//     done            one-cycle pulse after the last pixel is accepted
//   Read data is registered once before the compare, so the final bin of a
//   pixel settles in the tracker during the first EMIT cycle; out_valid is a
//   register set in that cycle, giving 2**NB+2 cycles from first read to result.
// -----------------------------------------------------------------------------
module his_peak_finder
    import his_peak_finder_pkg::*;
#(
    parameter int NB        = HPF_NB,
    parameter int PIXEL_NUM = HPF_PIXEL_NUM,
    parameter int CNT_W     = HPF_CNT_W,
    parameter int MIN_PEAK  = HPF_MIN_PEAK,
    parameter int PIX_W     = HPF_PIX_W
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    input  logic                bank_in,
    output logic                rd_en,
    output logic                rd_bank,
    output logic [PIX_W+NB-1:0] rd_addr,
    input  logic [CNT_W-1:0]    rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PIX_W-1:0]    out_pixel,
    output logic [NB-1:0]       out_bin,
    output logic [CNT_W-1:0]    out_count,
    output logic                out_no_target,
    output logic                busy,
    output logic                done
);

    localparam logic [NB-1:0]    BIN_LAST = '1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXEL_NUM - 1);
    localparam logic [CNT_W-1:0] MIN_PK   = CNT_W'(MIN_PEAK);

    hpf_state_e       state_q, state_d;
    logic [PIX_W-1:0] pixel_q, pixel_d;
    logic [NB-1:0]    bin_q, bin_d;
    logic             bank_q, bank_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    logic             trk_clear;

    // Read return pipeline: [0] = rd_data valid, [1] = rdat_q valid.
    logic [1:0]         vld_pipe_q;
    logic [1:0][NB-1:0] bin_pipe_q;
    logic [CNT_W-1:0]   rdat_q;

    logic [CNT_W-1:0] trk_max;
    logic [NB-1:0]    trk_idx;

    always_comb begin
        state_d     = state_q;
        pixel_d     = pixel_q;
        bin_d       = bin_q;
        bank_d      = bank_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        trk_clear   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bank_d    = bank_in;
                    pixel_d   = '0;
                    bin_d     = '0;
                    trk_clear = 1'b1;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                // bin holds at its last value until the pixel changes
                if (bin_q == BIN_LAST) state_d = ST_DRAIN;
                else                   bin_d   = bin_q + NB'(1);
            end
            ST_DRAIN: state_d = ST_EMIT;
            ST_EMIT: begin
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    bin_d       = '0;
                    if (pixel_q == PIX_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        pixel_d = pixel_q + PIX_W'(1);
                        state_d = ST_READ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= ST_IDLE;
            pixel_q     <= '0;
            bin_q       <= '0;
            bank_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            vld_pipe_q  <= '0;
            bin_pipe_q  <= '0;
            rdat_q      <= '0;
        end else begin
            state_q       <= state_d;
            pixel_q       <= pixel_d;
            bin_q         <= bin_d;
            bank_q        <= bank_d;
            out_valid_q   <= out_valid_d;
            done_q        <= done_d;
            vld_pipe_q    <= {vld_pipe_q[0], rd_en};
            bin_pipe_q[0] <= bin_q;
            bin_pipe_q[1] <= bin_pipe_q[0];
            rdat_q        <= rd_data;
        end
    end

    his_peak_finder_peak_tracker #(
        .NB    (NB),
        .CNT_W (CNT_W)
    ) u_trk (
        .clk          (clk),
        .res          (res),
        .clear_i      (trk_clear),
        .data_valid_i (vld_pipe_q[1]),
        .data_i       (rdat_q),
        .bin_i        (bin_pipe_q[1]),
        .max_o        (trk_max),
        .idx_o        (trk_idx)
    );

    assign rd_en         = (state_q == ST_READ);
    assign rd_addr       = rd_en ? (PIX_W+NB)'(his_addr(32'(pixel_q), 32'(bin_q), NB)) : '0;
    assign rd_bank       = bank_q;
    assign out_valid     = out_valid_q;
    assign out_pixel     = out_valid_q ? pixel_q : '0;
    assign out_bin       = out_valid_q ? trk_idx : '0;
    assign out_count     = out_valid_q ? trk_max : '0;
    assign out_no_target = out_valid_q && (trk_max < MIN_PK);
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_his_peak_finder.sv
// -----------------------------------------------------------------------------
// tb_his_peak_finder
//   Histogram RAM model plus a cycle-level reference model of the scan:
//   per pixel, reads at t = 0..2**NB-1, result from t = 2**NB+2 until accepted.
//   Peak = first maximum over the bins held in the RAM model.
// -----------------------------------------------------------------------------
module tb_his_peak_finder;

    localparam int NB        = 5;
    localparam int PIXEL_NUM = 4;
    localparam int CNT_W     = 8;
    localparam int MIN_PEAK  = 2;
    localparam int PIX_W     = 8;
    localparam int NBINS     = 1 << NB;
    localparam int LAT       = NBINS + 2;

    logic                clk = 1'b0;
    logic                res, start, bank_in;
    logic                rd_en, rd_bank;
    logic [PIX_W+NB-1:0] rd_addr;
    logic [CNT_W-1:0]    rd_data = '0;
    logic                out_valid, out_ready, out_no_target, busy, done;
    logic [PIX_W-1:0]    out_pixel;
    logic [NB-1:0]       out_bin;
    logic [CNT_W-1:0]    out_count;

    logic rand_rdy = 1'b0;
    logic rnd_rdy  = 1'b0;
    logic rdy_fix  = 1'b1;
    assign out_ready = rand_rdy ? rnd_rdy : rdy_fix;

    logic [CNT_W-1:0] mem [2][PIXEL_NUM][NBINS];

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    bit   chk_en = 1'b0;
    bit   m_act  = 1'b0;
    bit   m_done = 1'b0;
    logic m_bank = 1'b0;
    int   m_pix  = 0;
    int   m_t    = 0;

    his_peak_finder dut (
        .clk           (clk),
        .res           (res),
        .start         (start),
        .bank_in       (bank_in),
        .rd_en         (rd_en),
        .rd_bank       (rd_bank),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pixel     (out_pixel),
        .out_bin       (out_bin),
        .out_count     (out_count),
        .out_no_target (out_no_target),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // 1-cycle latency RAM; garbage on idle cycles exposes misaligned sampling
    always @(posedge clk) begin
        int p, b;
        p = int'(rd_addr) / NBINS;
        b = int'(rd_addr) % NBINS;
        if (rd_en && p < PIXEL_NUM) rd_data <= mem[rd_bank][p][b];
        else                        rd_data <= CNT_W'($urandom);
    end

    always @(posedge clk) begin
        #1 rnd_rdy = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void peak(input int b, input int p, output int bi, output int c);
        bi = 0;
        c  = int'(mem[b][p][0]);
        for (int k = 1; k < NBINS; k++)
            if (int'(mem[b][p][k]) > c) begin
                c  = int'(mem[b][p][k]);
                bi = k;
            end
    endfunction

    // compare process: check against the model, then advance the model
    always @(negedge clk) begin
        bit exp_rd, exp_ov;
        int pb, pc;
        exp_rd = m_act && (m_t < NBINS);
        exp_ov = m_act && (m_t >= LAT);
        if (chk_en) begin
            chk("rd_en", rd_en, exp_rd);
            chk("rd_addr", rd_addr, exp_rd ? m_pix * NBINS + m_t : 0);
            chk("rd_bank", rd_bank, m_bank);
            chk("busy", busy, m_act);
            chk("done", done, m_done);
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                peak(m_bank, m_pix, pb, pc);
                chk("out_pixel", out_pixel, m_pix);
                chk("out_bin", out_bin, pb);
                chk("out_count", out_count, pc);
                chk("out_no_target", out_no_target, pc < MIN_PEAK);
            end else begin
                chk("idle_fields", {out_pixel, out_bin, out_count, out_no_target}, 0);
            end
        end
        m_done = 1'b0;
        if (res) begin
            m_act  = 1'b0;
            m_bank = 1'b0;
        end else if (m_act) begin
            if (exp_ov && out_ready) begin
                if (m_pix == PIXEL_NUM - 1) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_pix++;
                    m_t = 0;
                end
            end else if (!exp_ov) begin
                m_t++;
            end
        end else if (start) begin
            m_act  = 1'b1;
            m_bank = bank_in;
            m_pix  = 0;
            m_t    = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic b);
        start   = 1'b1;
        bank_in = b;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!out_valid && cyc < 400);
        if (!out_valid) chk("valid_timeout", out_valid, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 4000) begin
            step();
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic exp_res(input int pix, input int bin, input int cnt, input int nt);
        chk("lit_pixel", out_pixel, pix);
        chk("lit_bin", out_bin, bin);
        chk("lit_count", out_count, cnt);
        chk("lit_no_target", out_no_target, nt);
    endtask

    task automatic fill_rand(input int b, input int maxv);
        for (int p = 0; p < PIXEL_NUM; p++)
            for (int k = 0; k < NBINS; k++)
                mem[b][p][k] = CNT_W'($urandom_range(0, maxv));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [31:0] held;
        res     = 1'b1;
        start   = 1'b0;
        bank_in = 1'b0;
        for (int b = 0; b < 2; b++) fill_rand(b, 0);
        step();
        chk_en = 1'b1;
        step();
        res = 1'b0;
        repeat (8) begin
            step();
            chk("idle_rd_en", rd_en, 0);
        end

        // single peak on bank 1
        for (int k = 0; k < NBINS; k++) mem[1][0][k] = 8'd1;
        mem[1][0][13] = 8'd9;
        for (int p = 1; p < PIXEL_NUM; p++)
            for (int k = 0; k < NBINS; k++) mem[1][p][k] = CNT_W'($urandom_range(0, 255));
        pulse_start(1'b1);
        chk("A_rd_bank", rd_bank, 1);
        chk("A_first_addr", {rd_en, 32'(rd_addr)}, {1'b1, 32'd0});
        wait_valid(cyc);
        chk("A_latency", cyc, 34);
        exp_res(0, 13, 9, 0);
        wait_done();

        // tie, all-zero, sub-threshold and saturated pixels on bank 0
        fill_rand(0, 0);
        mem[0][0][4]  = 8'd7;
        mem[0][0][20] = 8'd7;
        mem[0][2][30] = 8'd1;
        for (int k = 0; k < NBINS; k++) mem[0][3][k] = 8'hFF;
        step();
        pulse_start(1'b0);
        wait_valid(cyc);
        exp_res(0, 4, 7, 0);
        wait_valid(cyc);
        exp_res(1, 0, 0, 1);
        wait_valid(cyc);
        exp_res(2, 30, 1, 1);
        wait_valid(cyc);
        exp_res(3, 0, 255, 0);
        wait_done();

        // backpressure on pixel 1 with an ignored second start
        fill_rand(1, 255);
        step();
        pulse_start(1'b1);
        wait_valid(cyc);
        step();
        rdy_fix = 1'b0;
        wait_valid(cyc);
        held = {out_pixel, out_bin, out_count, out_no_target};
        for (int i = 0; i < 10; i++) begin
            if (i == 3) pulse_start(1'b0);
            else        step();
            chk("C_hold", {out_pixel, out_bin, out_count, out_no_target}, held);
            chk("C_hold_rd_en", rd_en, 0);
        end
        rdy_fix = 1'b1;
        step();
        chk("C_pix2_read", {rd_en, 32'(rd_addr)}, {1'b1, 32'(2 * NBINS)});
        chk("C_bank_kept", rd_bank, 1);
        wait_valid(cyc);
        wait_valid(cyc);
        chk("C_last_pixel", out_pixel, 3);
        wait_done();

        // reset in the middle of pixel 1
        fill_rand(0, 255);
        fill_rand(1, 255);
        step();
        pulse_start(1'b0);
        cyc = 0;
        while (!(rd_en && rd_addr == (PIX_W+NB)'(NBINS + 10)) && cyc < 400) begin
            step();
            cyc++;
        end
        chk("D_reached_bin10", rd_addr, NBINS + 10);
        res = 1'b1;
        step();
        res = 1'b0;
        chk("D_reset_state", {busy, out_valid, rd_en}, 0);
        step();
        pulse_start(1'b1);
        chk("D_restart", {rd_en, rd_bank, 32'(rd_addr)}, {1'b1, 1'b1, 32'd0});
        wait_done();

        // randomized scans with random backpressure
        rand_rdy = 1'b1;
        for (int it = 0; it < 12; it++) begin
            fill_rand(0, (it % 3 == 0) ? 3 : 255);
            fill_rand(1, (it % 2 == 0) ? 1 : 200);
            repeat ($urandom_range(1, 4)) step();
            pulse_start(1'($urandom_range(0, 1)));
            wait_done();
        end
        rand_rdy = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
